alu_op_sequencer: RTL and testbench

//  Initiator for the 8-bit ALU opcode/operand interface. Holds a small program of {opcode,a,b} steps,

---
 rtl/alu_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Initiator for the 8-bit ALU opcode/operand interface. A small register-file
//   program of {opcode, a, b} steps is loaded by the host. On start the steps
//   are issued one per clock onto opcode/a/b. The ALU registered result that
//   returns on z_in is captured for every step whose opcode[7] is set. done
//   pulses once the run completes normally.
//
//   Optional feature: define ALU_SEQ_LOOP_EN to add loop_cnt. The program then
//   repeats loop_cnt+1 passes. The pointer wraps from the last step back to 0
//   with no gap cycle.
//
// Ports
//   clk, rst_n       clock (posedge) and asynchronous active-low reset
//   prog_we/addr/data program write port {opcode[23:16], a[15:8], b[7:0]},
//                     accepted in IDLE only
//   last_addr        index of the final step, sampled with start
//   loop_cnt         extra passes, sampled with start (ALU_SEQ_LOOP_EN only)
//   start, abort     begin a run (IDLE only) / terminate a run
//   opcode, a, b     drive the ALU inputs; 8'h00 (NOP) outside RUN
//   z_in             ALU registered result, one cycle after the step
//   result           last captured z_in
//   result_valid     1-cycle pulse when result is updated
//   busy             state != IDLE
//   done             1-cycle pulse on the first IDLE cycle after DRAIN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_op_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [23:0]   prog_data,
  input  logic [AW-1:0] last_addr,
`ifdef ALU_SEQ_LOOP_EN
  input  logic [7:0]    loop_cnt,
`endif
  input  logic          start,
  input  logic          abort,
  output logic [7:0]    opcode,
  output logic [7:0]    a,
  output logic [7:0]    b,
  input  logic [7:0]    z_in,
  output logic [7:0]    result,
  output logic          result_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] last_addr_q;
  logic          cap_d1;
  logic [23:0]   prog_q [DEPTH];
  logic [23:0]   step_w;
  logic          in_run;
  logic          launch;
  logic          at_last;
  logic          final_step;
  logic          kill;

`ifdef ALU_SEQ_LOOP_EN
  logic [7:0]    loop_q;
  assign final_step = at_last && (loop_q == 8'd0);
`else
  assign final_step = at_last;
`endif

  assign in_run  = (state_q == RUN);
  assign busy    = (state_q != IDLE);
  assign launch  = (state_q == IDLE) && start && !abort;
  assign at_last = (ptr_q == last_addr_q);
  // An abort only means something while a run is in progress.
  assign kill    = busy && abort;
  assign step_w  = prog_q[ptr_q];

  // The ALU sees NOP (all zero) whenever no step is being issued.
  assign opcode = in_run ? step_w[23:16] : 8'h00;
  assign a      = in_run ? step_w[15:8]  : 8'h00;
  assign b      = in_run ? step_w[7:0]   : 8'h00;

  // Next-state logic.
  // NOTE: state_d gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (abort) state_d = IDLE;
               else if (final_step) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      last_addr_q  <= '0;
      cap_d1       <= 1'b0;
      result       <= 8'h00;
      result_valid <= 1'b0;
      done         <= 1'b0;
`ifdef ALU_SEQ_LOOP_EN
      loop_q       <= 8'd0;
`endif
    end else begin
      state_q <= state_d;

      if (launch) begin
        ptr_q       <= '0;
        last_addr_q <= last_addr;
`ifdef ALU_SEQ_LOOP_EN
        loop_q      <= loop_cnt;
`endif
      end else if (in_run && !abort) begin
        if (!at_last) begin
          ptr_q <= ptr_q + AW'(1);
        end
`ifdef ALU_SEQ_LOOP_EN
        else if (loop_q != 8'd0) begin
          ptr_q  <= '0;
          loop_q <= loop_q - 8'd1;
        end
`endif
      end

      // z_in is valid one cycle after the step, so capture is delayed one cycle.
      cap_d1       <= in_run && step_w[23] && !abort;
      // A capture already in flight is discarded on abort.
      result_valid <= cap_d1 && !kill;
      if (cap_d1 && !kill) begin
        result <= z_in;
      end

      done <= (state_q == DRAIN) && !abort;
    end
  end

  // Program store; writes are dropped while a run is in progress.
  // NOTE: the program is a small register file that is cleared on reset, so it
  // is kept in its own reset loop rather than coded as an un-reset RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        prog_q[i] <= 24'h000000;
      end
    end else if (prog_we && (state_q == IDLE)) begin
      prog_q[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Directed bench for alu_op_sequencer. A behavioural ALU stand-in closes the
//   loop from opcode/a/b back to z_in. Its opcode decode:
//     sum = a + (op[3] ? RA : b); if op[5] then sum <<= op[1:0];
//     op[6] -> RA <= sum; op[7] -> RB <= sum; z = RB
//   Inputs are driven 1 ns after the rising edge and outputs are sampled at
//   that same point. Define ALU_SEQ_LOOP_EN to also exercise loop_cnt.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [23:0] prog_data;
  logic [3:0]  last_addr;
  logic        start;
  logic        abort;
  logic [7:0]  opcode, a, b;
  logic [7:0]  z_in;
  logic [7:0]  result;
  logic        result_valid;
  logic        busy;
  logic        done;
`ifdef ALU_SEQ_LOOP_EN
  logic [7:0]  loop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Observations collected by watch().
  int          rv_cnt;
  int          done_cnt;
  logic        done_with_rv;
  logic [7:0]  res_q [$];

  alu_op_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .last_addr    (last_addr),
`ifdef ALU_SEQ_LOOP_EN
    .loop_cnt     (loop_cnt),
`endif
    .start        (start),
    .abort        (abort),
    .opcode       (opcode),
    .a            (a),
    .b            (b),
    .z_in         (z_in),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU stand-in with registered RA/RB.
  logic [7:0] alu_ra, alu_rb, alu_sum;
  always_comb begin
    alu_sum = a + (opcode[3] ? alu_ra : b);
    if (opcode[5]) alu_sum = alu_sum << opcode[1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ra <= 8'h00;
      alu_rb <= 8'h00;
    end else begin
      if (opcode[6]) alu_ra <= alu_sum;
      if (opcode[7]) alu_rb <= alu_sum;
    end
  end
  assign z_in = alu_rb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [3:0] addr, input logic [23:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    step();
    prog_we   = 1'b0;
  endtask

  // Pulse start for one cycle; returns in the first RUN cycle.
  task automatic launch(input logic [3:0] last);
    last_addr = last;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Sample the current cycle and the next n-1 cycles.
  task automatic watch(input int n);
    rv_cnt       = 0;
    done_cnt     = 0;
    done_with_rv = 1'b0;
    res_q.delete();
    for (int i = 0; i < n; i++) begin
      if (result_valid) begin
        rv_cnt++;
        res_q.push_back(result);
      end
      if (done) begin
        done_cnt++;
        if (result_valid) done_with_rv = 1'b1;
      end
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [7:0] got_res;
    rst_n     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    last_addr = '0;
    start     = 1'b0;
    abort     = 1'b0;
`ifdef ALU_SEQ_LOOP_EN
    loop_cnt  = 8'd0;
`endif

    // Reset state.
    #12;
    check("rst_opcode", opcode, 8'h00);
    check("rst_a", a, 8'h00);
    check("rst_b", b, 8'h00);
    check("rst_result", result, 8'h00);
    check("rst_rv", result_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single step, cycle by cycle.
    prog_write(4'd0, 24'h820503);
    launch(4'd0);
    check("single_c1_opcode", opcode, 8'h82);
    check("single_c1_a", a, 8'h05);
    check("single_c1_busy", busy, 1'b1);
    step();
    check("single_c2_busy", busy, 1'b1);
    check("single_c2_opcode", opcode, 8'h00);
    check("single_c2_done", done, 1'b0);
    step();
    check("single_c3_done", done, 1'b1);
    check("single_c3_rv", result_valid, 1'b1);
    check("single_c3_result", result, 8'h08);
    check("single_c3_busy", busy, 1'b0);
    step();
    check("single_c4_done", done, 1'b0);
    check("single_c4_rv", result_valid, 1'b0);

    // RA chaining; last_addr changes after start must not matter.
    prog_write(4'd0, 24'h41000A);
    prog_write(4'd1, 24'h8A0500);
    launch(4'd1);
    last_addr = 4'd15;
    check("chain_c1_opcode", opcode, 8'h41);
    step();
    check("chain_c2_opcode", opcode, 8'h8A);
    step();
    check("chain_c3_drain", busy, 1'b1);
    check("chain_c3_opcode", opcode, 8'h00);
    watch(4);
    check("chain_rv_cnt", rv_cnt, 1);
    check("chain_done_cnt", done_cnt, 1);
    check("chain_coincident", done_with_rv, 1'b1);
    check("chain_result", result, 8'h0F);

    // Shift wrap; the write and start share an IDLE cycle.
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = 24'hA24001;
    launch(4'd0);
    prog_we   = 1'b0;
    check("shift_new_data", opcode, 8'hA2);
    watch(4);
    check("shift_rv_cnt", rv_cnt, 1);
    check("shift_result", result, 8'h04);

    // Start and program writes while busy are ignored.
    prog_write(4'd0, 24'h820503);
    launch(4'd0);
    start     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = 24'hFFFFFF;
    step();
    check("ign_c2_opcode", opcode, 8'h00);
    step();
    start   = 1'b0;
    prog_we = 1'b0;
    check("ign_c3_done", done, 1'b1);
    check("ign_c3_result", result, 8'h08);
    step();
    check("ign_no_restart", busy, 1'b0);
    launch(4'd0);
    check("ign_rerun_opcode", opcode, 8'h82);
    check("ign_rerun_b", b, 8'h03);
    watch(4);
    check("ign_rerun_rv_cnt", rv_cnt, 1);
    check("ign_rerun_result", result, 8'h08);

    // Abort in the second RUN cycle of a 4-step program.
    prog_write(4'd0, 24'h820101);
    prog_write(4'd1, 24'h820202);
    prog_write(4'd2, 24'h820303);
    prog_write(4'd3, 24'h820404);
    launch(4'd3);
    step();
    check("abort_c2_opcode", opcode, 8'h82);
    check("abort_c2_a", a, 8'h02);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_opcode", opcode, 8'h00);
    check("abort_busy", busy, 1'b0);
    watch(6);
    check("abort_rv_cnt", rv_cnt, 0);
    check("abort_done_cnt", done_cnt, 0);

    // Abort wins over start in IDLE.
    abort = 1'b1;
    launch(4'd0);
    abort = 1'b0;
    check("abort_start_idle", busy, 1'b0);

    // Asynchronous reset mid-run clears everything, program included.
    launch(4'd3);
    check("midrst_running", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_opcode", opcode, 8'h00);
    check("midrst_result", result, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    launch(4'd0);
    check("cleared_busy", busy, 1'b1);
    check("cleared_opcode", opcode, 8'h00);
    watch(4);
    check("cleared_rv_cnt", rv_cnt, 0);
    check("cleared_done_cnt", done_cnt, 1);

`ifdef ALU_SEQ_LOOP_EN
    // Three passes of an accumulate step; RA starts from reset.
    do_reset();
    prog_write(4'd0, 24'hCA0100);
    loop_cnt = 8'd2;
    launch(4'd0);
    loop_cnt = 8'd0;
    watch(8);
    check("loop_rv_cnt", rv_cnt, 3);
    check("loop_done_cnt", done_cnt, 1);
    check("loop_coincident", done_with_rv, 1'b1);
    for (int i = 0; i < 3; i++) begin
      got_res = (i < res_q.size()) ? res_q[i] : 8'hEE;
      check($sformatf("loop_res%0d", i), got_res, 32'(i + 1));
    end
`else
    got_res = 8'h00;
    do_reset();
    check("final_rst_busy", busy, 1'b0);
    check("final_rst_result", result, {24'h0, got_res});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
